// File: rtl/fwft_byte_deframer.sv
// fwft_byte_deframer
// Pulls bytes from the 8-bit read side of an asymmetric FWFT FIFO, hunts for
// SOF_BYTE, reads a one-byte length and forwards that many payload bytes on a
// valid/ready stream with out_last marking the final byte.
// Define DEFRAMER_CHECKSUM_EN to expect a trailing XOR checksum byte per frame
// (XOR of len and all payload bytes); without it the frame ends at the last
// payload byte.
module fwft_byte_deframer #(
  parameter logic [7:0] SOF_BYTE  = 8'hA5,
  parameter int         CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 fifo_rd_en,
  input  logic [7:0]           fifo_rd_data,
  input  logic                 fifo_empty,
  output logic                 out_valid,
  output logic [7:0]           out_data,
  output logic                 out_last,
  input  logic                 out_ready,
  output logic                 frame_err,
  output logic [CNT_WIDTH-1:0] frame_count,
  output logic [CNT_WIDTH-1:0] drop_count
);

  localparam logic [1:0] ST_HUNT    = 2'd0;
  localparam logic [1:0] ST_LEN     = 2'd1;
  localparam logic [1:0] ST_PAYLOAD = 2'd2;
`ifdef DEFRAMER_CHECKSUM_EN
  localparam logic [1:0] ST_CHK     = 2'd3;
`endif

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  // Saturating increment shared by both statistics counters.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    logic [CNT_WIDTH-1:0] r;
    if (v == CNT_MAX) begin
      r = v;
    end else begin
      r = v + CNT_WIDTH'(1);
    end
    return r;
  endfunction

`ifdef DEFRAMER_CHECKSUM_EN
  // Running XOR checksum step.
  function automatic logic [7:0] xor_acc(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction
`endif

  logic [1:0] state_r;
  logic [7:0] remaining_r;
  logic       pop_s;
  logic       last_byte_s;
`ifdef DEFRAMER_CHECKSUM_EN
  logic [7:0] acc_r;
`endif

  assign last_byte_s = (remaining_r == 8'd1);
  assign fifo_rd_en  = pop_s;

  // Pop decision: depends only on state, output handshake and FIFO flag; never pops when empty or in reset.
  always_comb begin
    pop_s = 1'b0;
    if (!rst_n || fifo_empty) begin
      pop_s = 1'b0;
    end else begin
      case (state_r)
        ST_HUNT:    pop_s = 1'b1;
        ST_LEN:     pop_s = 1'b1;
        ST_PAYLOAD: pop_s = !out_valid || out_ready;
`ifdef DEFRAMER_CHECKSUM_EN
        ST_CHK:     pop_s = 1'b1;
`endif
        default:    pop_s = 1'b0;
      endcase
    end
  end

  // Frame FSM, length tracking, error pulse and saturating statistics.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_HUNT;
      remaining_r <= 8'd0;
      frame_err   <= 1'b0;
      frame_count <= '0;
      drop_count  <= '0;
`ifdef DEFRAMER_CHECKSUM_EN
      acc_r       <= 8'd0;
`endif
    end else begin
      frame_err <= 1'b0;
      if (pop_s) begin
        case (state_r)
          ST_HUNT: begin
            if (fifo_rd_data == SOF_BYTE) begin
              state_r <= ST_LEN;
`ifdef DEFRAMER_CHECKSUM_EN
              acc_r   <= 8'd0;
`endif
            end else begin
              drop_count <= sat_inc(drop_count);
            end
          end
          ST_LEN: begin
            remaining_r <= fifo_rd_data;
`ifdef DEFRAMER_CHECKSUM_EN
            acc_r       <= xor_acc(acc_r, fifo_rd_data);
`endif
            if (fifo_rd_data == 8'd0) begin
              frame_err <= 1'b1;
              state_r   <= ST_HUNT;
            end else begin
              state_r   <= ST_PAYLOAD;
            end
          end
          ST_PAYLOAD: begin
            remaining_r <= remaining_r - 8'd1;
`ifdef DEFRAMER_CHECKSUM_EN
            acc_r       <= xor_acc(acc_r, fifo_rd_data);
            if (last_byte_s) begin
              state_r <= ST_CHK;
            end
`else
            if (last_byte_s) begin
              frame_count <= sat_inc(frame_count);
              state_r     <= ST_HUNT;
            end
`endif
          end
`ifdef DEFRAMER_CHECKSUM_EN
          ST_CHK: begin
            if (fifo_rd_data == acc_r) begin
              frame_count <= sat_inc(frame_count);
            end else begin
              frame_err   <= 1'b1;
            end
            state_r <= ST_HUNT;
          end
`endif
          default: state_r <= ST_HUNT;
        endcase
      end
    end
  end

  // Output register: load on a payload pop, otherwise drop valid once accepted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= 8'd0;
      out_last  <= 1'b0;
    end else if (pop_s && (state_r == ST_PAYLOAD)) begin
      out_valid <= 1'b1;
      out_data  <= fifo_rd_data;
      out_last  <= last_byte_s;
    end else if (out_ready) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

endmodule
